// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
// Request fields are registered in the master; rdata is only meaningful while ack is high.
interface mem_access_stage_if #(
    parameter int N = 32
);
    logic         dmem_req_o;
    logic         dmem_we_o;
    logic [N-1:0] dmem_addr_o;
    logic [N-1:0] dmem_wdata_o;
    logic [3:0]   dmem_be_o;
    logic [N-1:0] dmem_rdata_i;
    logic         dmem_ack_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        input  dmem_rdata_i, dmem_ack_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        output dmem_rdata_i, dmem_ack_i
    );
endinterface

// File: rtl/mem_access_stage.sv
// RISC-V memory-access stage: single-cycle ALU passthrough, req/ack load/store with upstream stall,
// store byte-lane steering and load sign/zero extension into the MEM/WB register.
module mem_access_stage #(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [N-1:0]         alu_result_i,
    input  logic                 write_i,
    input  logic [4:0]           write_register_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [2:0]           funct3_i,
    input  logic [N-1:0]         store_data_i,
    output logic                 stall_o,
    output logic                 misalign_o,
    mem_access_stage_if.master   dmem,
    output logic [N-1:0]         wb_data_o,
    output logic                 wb_write_o,
    output logic [4:0]           wb_rd_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t       state_reg, state_next;

    logic         req_reg, we_reg;
    logic [N-1:0] addr_reg, wdata_reg, rdata_reg;
    logic [3:0]   be_reg;
    logic [1:0]   lane_reg;
    logic [2:0]   funct3_reg;
    logic         kill_reg;
    logic [N-1:0] wb_data_reg;
    logic         wb_write_reg;
    logic [4:0]   wb_rd_reg;

    logic         memop, misaligned, start, stall;
    logic [N-1:0] wdata_steer, wdata_byte, load_data;
    logic [3:0]   be_steer;
    logic [7:0]   rbyte [4];
    logic [7:0]   sel_byte;
    logic [15:0]  sel_half;

    assign memop      = mem_read_i | mem_write_i;
    assign misaligned = ((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));
    assign start      = memop && !misaligned && flush;

    // Byte lanes of the latched read word and the replicated store byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi]             = rdata_reg[8*gi +: 8];
            assign wdata_byte[8*gi +: 8] = store_data_i[7:0];
        end
    endgenerate

    always_comb begin
        wdata_steer = store_data_i;
        be_steer    = 4'b1111;
        if (mem_write_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    wdata_steer = wdata_byte;
                    be_steer    = 4'b0001 << alu_result_i[1:0];
                end
                2'b01: begin
                    wdata_steer = {2{store_data_i[15:0]}};
                    be_steer    = 4'b0011 << {alu_result_i[1], 1'b0};
                end
                default: begin
                    wdata_steer = store_data_i;
                    be_steer    = 4'b1111;
                end
            endcase
        end
    end

    assign sel_byte = rbyte[lane_reg];
    assign sel_half = lane_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];

    always_comb begin
        case (funct3_reg)
            3'b000:  load_data = {{(N-8){sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {{(N-8){1'b0}}, sel_byte};
            3'b001:  load_data = {{(N-16){sel_half[15]}}, sel_half};
            3'b101:  load_data = {{(N-16){1'b0}}, sel_half};
            default: load_data = rdata_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = REQ;
            REQ:     if (dmem.dmem_ack_i) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are gated by reset so everything reads 0 while reset is held.
    always_comb begin
        stall      = ((state_reg == IDLE) && start) || (state_reg == REQ);
        stall_o    = reset && stall;
        misalign_o = reset && (state_reg == IDLE) && memop && misaligned && flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_reg      <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            be_reg       <= 4'b0000;
            lane_reg     <= 2'b00;
            funct3_reg   <= 3'b000;
            rdata_reg    <= '0;
            kill_reg     <= 1'b0;
            wb_data_reg  <= '0;
            wb_write_reg <= 1'b0;
            wb_rd_reg    <= 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        req_reg    <= 1'b1;
                        we_reg     <= mem_write_i;
                        addr_reg   <= {alu_result_i[N-1:2], 2'b00};
                        wdata_reg  <= wdata_steer;
                        be_reg     <= be_steer;
                        lane_reg   <= alu_result_i[1:0];
                        funct3_reg <= funct3_i;
                    end
                end
                REQ: begin
                    // A flush never aborts the bus access, it only suppresses writeback.
                    if (!flush) kill_reg <= 1'b1;
                    if (dmem.dmem_ack_i) begin
                        rdata_reg <= dmem.dmem_rdata_i;
                        req_reg   <= 1'b0;
                    end
                end
                RESP:    kill_reg <= 1'b0;
                default: kill_reg <= 1'b0;
            endcase

            if (!flush || stall || ((state_reg == IDLE) && memop)) begin
                wb_data_reg  <= '0;
                wb_write_reg <= 1'b0;
                wb_rd_reg    <= 5'd0;
            end else if (state_reg == IDLE) begin
                wb_data_reg  <= alu_result_i;
                wb_write_reg <= write_i;
                wb_rd_reg    <= write_register_i;
            end else if ((state_reg == RESP) && !kill_reg) begin
                wb_data_reg  <= mem_read_i ? load_data : alu_result_i;
                wb_write_reg <= mem_read_i ? write_i : 1'b0;
                wb_rd_reg    <= write_register_i;
            end else begin
                wb_data_reg  <= '0;
                wb_write_reg <= 1'b0;
                wb_rd_reg    <= 5'd0;
            end
        end
    end

    assign dmem.dmem_req_o   = req_reg;
    assign dmem.dmem_we_o    = we_reg;
    assign dmem.dmem_addr_o  = addr_reg;
    assign dmem.dmem_wdata_o = wdata_reg;
    assign dmem.dmem_be_o    = be_reg;
    assign wb_data_o         = wb_data_reg;
    assign wb_write_o        = wb_write_reg;
    assign wb_rd_o           = wb_rd_reg;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: passthrough, loads, steered stores, misalignment,
// flush during a bus wait and reset during a request.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset, flush, write_i, mem_read_i, mem_write_i;
    logic [31:0] alu_result_i, store_data_i, wb_data_o;
    logic [4:0]  write_register_i, wb_rd_o;
    logic [2:0]  funct3_i;
    logic        stall_o, misalign_o, wb_write_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_stage_if #(.N(32)) dmem_bus ();

    mem_access_stage #(.N(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .alu_result_i     (alu_result_i),
        .write_i          (write_i),
        .write_register_i (write_register_i),
        .mem_read_i       (mem_read_i),
        .mem_write_i      (mem_write_i),
        .funct3_i         (funct3_i),
        .store_data_i     (store_data_i),
        .stall_o          (stall_o),
        .misalign_o       (misalign_o),
        .dmem             (dmem_bus),
        .wb_data_o        (wb_data_o),
        .wb_write_o       (wb_write_o),
        .wb_rd_o          (wb_rd_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic nop_inputs();
        alu_result_i     = 32'h0;
        write_i          = 1'b0;
        write_register_i = 5'd0;
        mem_read_i       = 1'b0;
        mem_write_i      = 1'b0;
        funct3_i         = 3'b000;
        store_data_i     = 32'h0;
    endtask

    task automatic load_txn(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp);
        alu_result_i = addr; mem_read_i = 1'b1; mem_write_i = 1'b0;
        funct3_i = f3; write_i = 1'b1; write_register_i = rd;
        #1;
        chk({tag, " stall idle"}, stall_o, 1);
        chk({tag, " misalign"}, misalign_o, 0);
        tick();
        chk({tag, " req"}, dmem_bus.dmem_req_o, 1);
        chk({tag, " addr"}, dmem_bus.dmem_addr_o, {addr[31:2], 2'b00});
        chk({tag, " be"}, dmem_bus.dmem_be_o, 4'b1111);
        chk({tag, " we"}, dmem_bus.dmem_we_o, 0);
        chk({tag, " stall req"}, stall_o, 1);
        dmem_bus.dmem_rdata_i = rdata; dmem_bus.dmem_ack_i = 1'b1;
        tick();
        dmem_bus.dmem_ack_i = 1'b0; dmem_bus.dmem_rdata_i = 32'h0;
        chk({tag, " req dropped"}, dmem_bus.dmem_req_o, 0);
        chk({tag, " stall resp"}, stall_o, 0);
        chk({tag, " wb_write resp"}, wb_write_o, 0);
        tick();
        chk({tag, " wb_data"}, wb_data_o, exp);
        chk({tag, " wb_write"}, wb_write_o, 1);
        chk({tag, " wb_rd"}, wb_rd_o, rd);
        nop_inputs();
        $display("txn %s addr=0x%08h wb_data=0x%08h", tag, addr, wb_data_o);
    endtask

    task automatic store_txn(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input logic [31:0] data, input logic [4:0] rd, input int waits,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        alu_result_i = addr; mem_read_i = 1'b0; mem_write_i = 1'b1;
        funct3_i = f3; store_data_i = data; write_i = 1'b1; write_register_i = rd;
        #1;
        chk({tag, " stall idle"}, stall_o, 1);
        tick();
        chk({tag, " req"}, dmem_bus.dmem_req_o, 1);
        chk({tag, " we"}, dmem_bus.dmem_we_o, 1);
        chk({tag, " addr"}, dmem_bus.dmem_addr_o, {addr[31:2], 2'b00});
        chk({tag, " be"}, dmem_bus.dmem_be_o, exp_be);
        chk({tag, " wdata"}, dmem_bus.dmem_wdata_o, exp_wdata);
        chk({tag, " stall req"}, stall_o, 1);
        chk({tag, " wb_write req"}, wb_write_o, 0);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk({tag, " stall wait"}, stall_o, 1);
            chk({tag, " req wait"}, dmem_bus.dmem_req_o, 1);
            chk({tag, " wb_write wait"}, wb_write_o, 0);
        end
        dmem_bus.dmem_ack_i = 1'b1;
        #1;
        chk({tag, " stall ack cycle"}, stall_o, 1);
        tick();
        dmem_bus.dmem_ack_i = 1'b0;
        chk({tag, " req dropped"}, dmem_bus.dmem_req_o, 0);
        chk({tag, " stall resp"}, stall_o, 0);
        chk({tag, " wb_write resp"}, wb_write_o, 0);
        tick();
        chk({tag, " wb_write"}, wb_write_o, 0);
        chk({tag, " wb_data"}, wb_data_o, addr);
        chk({tag, " wb_rd"}, wb_rd_o, rd);
        nop_inputs();
        $display("txn %s addr=0x%08h be=%b", tag, addr, exp_be);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b1;
        nop_inputs();
        dmem_bus.dmem_ack_i = 1'b0; dmem_bus.dmem_rdata_i = 32'h0;
        #1;
        chk("reset req", dmem_bus.dmem_req_o, 0);
        chk("reset wb_write", wb_write_o, 0);
        chk("reset stall", stall_o, 0);
        $display("txn reset checked");
        #11 reset = 1'b1;
        tick();

        // ALU passthrough, with a stray ack that must be ignored in IDLE
        alu_result_i = 32'h0000_1234; write_i = 1'b1; write_register_i = 5'd5;
        dmem_bus.dmem_ack_i = 1'b1;
        #1;
        chk("pass stall before", stall_o, 0);
        tick();
        chk("pass wb_data", wb_data_o, 32'h0000_1234);
        chk("pass wb_write", wb_write_o, 1);
        chk("pass wb_rd", wb_rd_o, 5'd5);
        chk("pass stall", stall_o, 0);
        chk("pass no req", dmem_bus.dmem_req_o, 0);
        dmem_bus.dmem_ack_i = 1'b0;
        nop_inputs();
        $display("txn passthrough wb_data=0x%08h", wb_data_o);

        load_txn("LB", 32'h0000_0103, 3'b000, 5'd7, 32'h80FF_FF00, 32'hFFFF_FF80);
        load_txn("LBU", 32'h0000_0103, 3'b100, 5'd7, 32'h80FF_FF00, 32'h0000_0080);
        load_txn("LH", 32'h0000_0102, 3'b001, 5'd8, 32'h80FF_FF00, 32'hFFFF_80FF);
        load_txn("LHU", 32'h0000_0102, 3'b101, 5'd8, 32'h80FF_FF00, 32'h0000_80FF);

        store_txn("SH", 32'h0000_0202, 3'b001, 32'h0000_ABCD, 5'd9, 2, 4'b1100, 32'hABCD_ABCD);
        store_txn("SB", 32'h0000_0401, 3'b000, 32'h1234_5678, 5'd10, 0, 4'b0010, 32'h7878_7878);

        // Misaligned accesses: pulse, no bus, no stall, bubble
        alu_result_i = 32'h0000_0301; mem_read_i = 1'b1; funct3_i = 3'b010;
        write_i = 1'b1; write_register_i = 5'd2;
        #1;
        chk("misLW misalign", misalign_o, 1);
        chk("misLW stall", stall_o, 0);
        tick();
        chk("misLW wb_write", wb_write_o, 0);
        chk("misLW req", dmem_bus.dmem_req_o, 0);
        alu_result_i = 32'h0000_0203; funct3_i = 3'b001;
        #1;
        chk("misLH misalign", misalign_o, 1);
        nop_inputs();
        #1;
        chk("misalign cleared", misalign_o, 0);
        $display("txn misaligned LW/LH");

        // SW flushed during the wait: bus write completes, writeback suppressed
        alu_result_i = 32'h0000_0500; mem_write_i = 1'b1; funct3_i = 3'b010;
        store_data_i = 32'hDEAD_BEEF; write_i = 1'b1; write_register_i = 5'd3;
        #1;
        chk("flushSW stall idle", stall_o, 1);
        tick();
        chk("flushSW be", dmem_bus.dmem_be_o, 4'b1111);
        chk("flushSW wdata", dmem_bus.dmem_wdata_o, 32'hDEAD_BEEF);
        flush = 1'b0;
        #1;
        chk("flushSW stall flushed", stall_o, 1);
        tick();
        flush = 1'b1;
        chk("flushSW req held", dmem_bus.dmem_req_o, 1);
        chk("flushSW we held", dmem_bus.dmem_we_o, 1);
        dmem_bus.dmem_ack_i = 1'b1;
        tick();
        dmem_bus.dmem_ack_i = 1'b0;
        chk("flushSW req dropped", dmem_bus.dmem_req_o, 0);
        tick();
        chk("flushSW wb_write", wb_write_o, 0);
        chk("flushSW wb_data", wb_data_o, 32'h0);
        chk("flushSW wb_rd", wb_rd_o, 5'd0);
        nop_inputs();
        alu_result_i = 32'h0000_0077; write_i = 1'b1; write_register_i = 5'd4;
        tick();
        chk("after flush wb_data", wb_data_o, 32'h0000_0077);
        chk("after flush wb_write", wb_write_o, 1);
        chk("after flush wb_rd", wb_rd_o, 5'd4);
        nop_inputs();
        $display("txn flushed SW then ALU wb_data=0x%08h", wb_data_o);

        // Reset while a load waits for ack
        alu_result_i = 32'h0000_0600; mem_read_i = 1'b1; funct3_i = 3'b010;
        write_i = 1'b1; write_register_i = 5'd6;
        tick();
        chk("rstREQ req before", dmem_bus.dmem_req_o, 1);
        #1 reset = 1'b0;
        #1;
        chk("rstREQ req", dmem_bus.dmem_req_o, 0);
        chk("rstREQ addr", dmem_bus.dmem_addr_o, 32'h0);
        chk("rstREQ be", dmem_bus.dmem_be_o, 4'b0000);
        chk("rstREQ stall", stall_o, 0);
        chk("rstREQ wb_data", wb_data_o, 32'h0);
        reset = 1'b1;
        $display("txn reset during REQ");
        load_txn("LW after reset", 32'h0000_0600, 3'b010, 5'd6, 32'h1234_5678, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the RISC-V pipeline, fed by the EX/MEM pipeline register and driving the MEM/WB pipeline register. Non-memory instructions pass through in one cycle. Loads and stores run a registered req/ack transaction on the data-memory bus and stall the upstream pipeline until it completes. The block does byte-lane steering for stores and sign/zero extension for loads.

## Interface
- N, 32, datapath width; 32 is the only supported value.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- flush  in  1  synchronous, active-low; 0 kills the instruction currently in the stage.
- alu_result_i  in  N  ALU result or effective address from EX/MEM.
- write_i  in  1  register-write enable from EX/MEM.
- write_register_i  in  5  destination register.
- mem_read_i / mem_write_i  in  1 each  load / store; never both 1.
- funct3_i  in  3  access size: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- store_data_i  in  N  rs2 value for stores.
- stall_o  out  1  1 holds EX/MEM and all earlier stages.
- misalign_o  out  1  one-cycle pulse on a misaligned access.
- dmem_req_o, dmem_we_o  out  1 each  bus request and write strobe (registered).
- dmem_addr_o  out  N  word-aligned address (alu_result_i with bits [1:0] forced to 00), registered.
- dmem_wdata_o  out  N  lane-steered store data, registered.
- dmem_be_o  out  4  byte enables, registered.
- dmem_rdata_i  in  N  read word, valid when dmem_ack_i=1.
- dmem_ack_i  in  1  completes the request.
- wb_data_o  out  N  MEM/WB data.
- wb_write_o  out  1  MEM/WB register-write enable.
- wb_rd_o  out  5  MEM/WB destination register.

## Operation
- FSM states and transitions:
  - IDLE: on mem_read_i or mem_write_i with an aligned address and flush=1, load the bus registers, go to REQ.
  - REQ: hold all bus outputs stable. Sample dmem_ack_i at each edge. On ack=1, latch dmem_rdata_i, drop dmem_req_o, go to RESP.
  - RESP: go to IDLE unconditionally.
- Kill flag: set when flush=0 in REQ; cleared on entering IDLE.
- stall_o = (IDLE & memop & aligned & flush) | REQ. It is 0 in RESP, so EX/MEM advances on the RESP edge.
- Misalignment rules:
  - Misaligned when LH/LHU/SH has addr[0]=1, or LW/SW has addr[1:0]≠00.
  - Result: misalign_o=1 for one cycle, no bus access, no stall, MEM/WB captures a bubble.
- Store steering:
  - SB: wdata = byte replicated ×4, be = 0001<<addr[1:0].
  - SH: wdata = halfword replicated ×2, be = 0011<<(2·addr[1]).
  - SW: be = 1111.
  - dmem_we_o=1 for stores only.
- Load extraction:
  - Select the lane from the latched word using addr[1:0] held in the bus register.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- MEM/WB register update, every edge, in this priority order:
  1. flush=0 → bubble.
  2. Stall cycle, or IDLE with misalign → bubble.
  3. IDLE non-memop → {alu_result_i, write_i, write_register_i}.
  4. RESP with kill=0 → load: {extracted data, write_i, rd}; store: {alu_result_i, 0, rd}.
  5. RESP with kill=1 → bubble.
- Bubble = wb_write_o=0, wb_data_o=0, wb_rd_o=0.
- Flush does not abort a bus transaction. A store killed in REQ still writes memory; only its writeback is suppressed.

## Timing
- Reset values (reset=0, immediate): every output is 0, state is IDLE, kill is 0. This also applies to reset asserted mid-REQ; the bus drops req without waiting for ack.
- Non-memory instruction: MEM/WB valid 1 edge after it appears at the inputs.
- Memory instruction, ack in the first REQ cycle:
  - Edge 1: IDLE→REQ.
  - Edge 2: ack sampled, REQ→RESP.
  - Edge 3: MEM/WB written, EX/MEM advances.
  - Total: 3 edges; each cycle of ack delay adds 1.
- dmem_ack_i is ignored in IDLE and RESP.
- dmem_req_o falls on the same edge ack is sampled.
- No back-to-back requests: a request can start no earlier than 1 cycle after RESP, i.e. at least 1 idle bus cycle between requests.

## Test plan
- ALU passthrough: alu_result_i=0x0000_1234, write_i=1, rd=5 → next edge wb_data_o=0x1234, wb_write_o=1, wb_rd_o=5, stall_o=0 throughout.
- LB sign extension: addr=0x103, rdata=0x80FF_FF00, ack on the first REQ cycle → dmem_addr_o=0x100, be=1111 ignored for reads, wb_data_o=0xFFFF_FF80 on edge 3. LBU with the same values → 0x0000_0080.
- SH steering with wait states: addr=0x202, store_data=0x0000_ABCD, ack after 3 REQ cycles:
  - Bus: be=1100, wdata=0xABCD_ABCD, we=1.
  - stall_o high for 4 cycles; wb_write_o=0 on every edge.
- Misaligned LW at addr=0x301 → misalign_o pulse, dmem_req_o stays 0, wb_write_o=0, no stall.
- Flush during REQ of SW: flush=0 one cycle mid-wait →
  - Bus write still completes with be=1111.
  - RESP edge writes a bubble (wb_write_o=0).
  - The next non-memory instruction writes back normally.
- Reset mid-REQ → all outputs 0 immediately. After release, a load completes normally with the 3-edge latency.
